// File: rtl/clock_set_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_pkg
// Shared constants for the time-setting controller:
//   - FSM state encoding (RUN / SET_HOUR / SET_MIN / SET_SEC)
//   - edit-field codes driven on edit_field (NONE / HOUR / MIN / SEC)
//   - field maxima used for wrap-around on increment
//   - default blink and timeout periods in sysclk cycles
//   - small helpers for wrapping increments and state->field mapping
// Optional feature macro: SET_TIMEOUT_EN (adds the idle-timeout default).
// -----------------------------------------------------------------------------
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // 0.5 s blink half-period at 50 MHz
  localparam int BLINK_CYCLES_DEF = 25_000_000;
`ifdef SET_TIMEOUT_EN
  // 10 s idle abort at 50 MHz
  localparam int TIMEOUT_CYCLES_DEF = 500_000_000;
`endif

  // ">=" rather than "==" so an out-of-range snapshot still wraps to 0.
  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_60(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    case (s)
      ST_SET_HOUR: f = FIELD_HOUR;
      ST_SET_MIN:  f = FIELD_MIN;
      ST_SET_SEC:  f = FIELD_SEC;
      default:     f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_blink.sv
// -----------------------------------------------------------------------------
// set_blink_gen
// Blink generator for the field under edit: a cycle counter plus a toggle flop.
//   sysclk  in  system clock
//   rst     in  synchronous active-high reset
//   clr     in  restart the blink phase: blink=1, counter=0
//   en      in  1 while the controller is (or is about to be) in a SET state;
//               0 forces blink=0 and holds the counter at 0
//   blink   out registered visibility flag, toggles every BLINK_CYCLES cycles
// -----------------------------------------------------------------------------
module set_blink_gen
  import clock_set_ctrl_pkg::*;
#(
  parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic blink
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  // en has priority over clr: a press that also leaves set mode must not
  // leave the display blanked/shown by a stale blink phase.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!en) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (clr) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller. Consumes 1-cycle short/long press pulses, edits a
// shadow copy of the time field by field and hands the result to the
// timekeeping counter with a 1-cycle load pulse.
//   sysclk          in   system clock
//   rst             in   synchronous active-high reset
//   short_pression  in   1-cycle short-press pulse
//   long_pression   in   1-cycle long-press pulse
//   cur_hour/min/sec in  live time, snapshotted on entry to set mode
//   set_mode        out  1 in any SET state
//   edit_field      out  0 none, 1 hour, 2 min, 3 sec
//   set_hour/min/sec out shadow time under edit
//   load_vld        out  1-cycle pulse; set_* carry the time to load
//   blink           out  visibility flag for the edited field, 0 in RUN
// Handshake: load_vld is a pure valid pulse with no ready; the receiver must
// take set_* in the cycle load_vld is high (they stay stable afterwards anyway).
// Optional feature macro: SET_TIMEOUT_EN adds an idle-timeout abort and the
// TIMEOUT_CYCLES parameter.
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
`ifdef SET_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       short_pression,
  input  logic       long_pression,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       set_mode,
  output logic [1:0] edit_field,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load_vld,
  output logic       blink
);

  state_e     state_q, state_d;
  logic [4:0] set_hour_q, set_hour_d;
  logic [5:0] set_min_q, set_min_d;
  logic [5:0] set_sec_q, set_sec_d;
  logic       load_q, load_d;
  logic       set_mode_q, set_mode_d;
  logic [1:0] edit_field_q, edit_field_d;

  logic press_acc;   // any press seen while already in a SET state
  logic entering;    // long press taking RUN into SET_HOUR
  logic blink_en;
  logic blink_clr;

`ifdef SET_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    load_d     = 1'b0;
    press_acc  = 1'b0;
    entering   = 1'b0;

    // long is tested first everywhere, so a simultaneous short is dropped.
    case (state_q)
      ST_RUN: begin
        if (long_pression) begin
          state_d    = ST_SET_HOUR;
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
          entering   = 1'b1;
        end
      end
      ST_SET_HOUR: begin
        press_acc = long_pression | short_pression;
        if (long_pression)       state_d    = ST_SET_MIN;
        else if (short_pression) set_hour_d = inc_hour(set_hour_q);
      end
      ST_SET_MIN: begin
        press_acc = long_pression | short_pression;
        if (long_pression)       state_d   = ST_SET_SEC;
        else if (short_pression) set_min_d = inc_60(set_min_q, MIN_MAX);
      end
      ST_SET_SEC: begin
        press_acc = long_pression | short_pression;
        if (long_pression) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (short_pression) begin
          set_sec_d = inc_60(set_sec_q, SEC_MAX);
        end
      end
      default: state_d = ST_RUN;
    endcase

`ifdef SET_TIMEOUT_EN
    // A press on the expiry cycle wins: it clears the counter instead.
    tmo_d = '0;
    if (state_q != ST_RUN && !press_acc) begin
      if (tmo_q == TMO_LAST) state_d = ST_RUN;
      else                   tmo_d   = tmo_q + 1'b1;
    end
`endif

    set_mode_d   = (state_d != ST_RUN);
    edit_field_d = field_of(state_d);
    blink_en     = (state_d != ST_RUN);
    blink_clr    = entering | press_acc;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      set_hour_q   <= '0;
      set_min_q    <= '0;
      set_sec_q    <= '0;
      load_q       <= 1'b0;
      set_mode_q   <= 1'b0;
      edit_field_q <= FIELD_NONE;
`ifdef SET_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      set_hour_q   <= set_hour_d;
      set_min_q    <= set_min_d;
      set_sec_q    <= set_sec_d;
      load_q       <= load_d;
      set_mode_q   <= set_mode_d;
      edit_field_q <= edit_field_d;
`ifdef SET_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  set_blink_gen #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .sysclk(sysclk),
    .rst   (rst),
    .clr   (blink_clr),
    .en    (blink_en),
    .blink (blink)
  );

  assign set_mode   = set_mode_q;
  assign edit_field = edit_field_q;
  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign load_vld   = load_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl (BLINK_CYCLES=4, TIMEOUT_CYCLES=20).
// Directed vector table, hand-written multi-cycle sequences (idle blink,
// timeout, reset mid-edit) and a randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int BLINK = 4;
  localparam int TMO   = 20;

  logic       sysclk;
  logic       rst;
  logic       short_pression;
  logic       long_pression;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       set_mode;
  logic [1:0] edit_field;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       load_vld;
  logic       blink;

  clock_set_ctrl #(
    .BLINK_CYCLES(BLINK)
`ifdef SET_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .short_pression(short_pression),
    .long_pression (long_pression),
    .cur_hour      (cur_hour),
    .cur_min       (cur_min),
    .cur_sec       (cur_sec),
    .set_mode      (set_mode),
    .edit_field    (edit_field),
    .set_hour      (set_hour),
    .set_min       (set_min),
    .set_sec       (set_sec),
    .load_vld      (load_vld),
    .blink         (blink)
  );

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // packed view: {set_mode, edit_field, hour, min, sec, load_vld, blink}
  function automatic logic [21:0] pack(input int mode, input int ef, input int h,
                                       input int mi, input int s, input int ld,
                                       input int bl);
    logic [21:0] p;
    p = {mode[0], ef[1:0], h[4:0], mi[5:0], s[5:0], ld[0], bl[0]};
    return p;
  endfunction

  function automatic logic [21:0] dut_out();
    return {set_mode, edit_field, set_hour, set_min, set_sec, load_vld, blink};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got mode=%0d fld=%0d %0d:%0d:%0d ld=%0d bl=%0d, expected mode=%0d fld=%0d %0d:%0d:%0d ld=%0d bl=%0d",
               name, act[21], act[20:19], act[18:14], act[13:8], act[7:2], act[1], act[0],
               exp[21], exp[20:19], exp[18:14], exp[13:8], exp[7:2], exp[1], exp[0]);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // field: 0 run, 1 hour, 2 min, 3 sec. since: cycles since the last press
  // (blink phase), idle: cycles without a press (timeout).
  int m_field, m_h, m_m, m_s, m_since, m_idle, m_load;

  function automatic void model_step(input bit r, input bit sh, input bit lg,
                                     input int ch, input int cm, input int cs);
    m_load = 0;
    if (r) begin
      m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_since = 0; m_idle = 0;
    end else if (m_field == 0) begin
      if (lg) begin
        m_field = 1; m_h = ch; m_m = cm; m_s = cs; m_since = 0; m_idle = 0;
      end
    end else if (lg) begin
      if (m_field == 3) begin
        m_field = 0;
        m_load  = 1;
      end else begin
        m_field = m_field + 1;
      end
      m_since = 0; m_idle = 0;
    end else if (sh) begin
      case (m_field)
        1:       m_h = (m_h >= 23) ? 0 : m_h + 1;
        2:       m_m = (m_m >= 59) ? 0 : m_m + 1;
        default: m_s = (m_s >= 59) ? 0 : m_s + 1;
      endcase
      m_since = 0; m_idle = 0;
    end else begin
      m_since = m_since + 1;
      m_idle  = m_idle + 1;
`ifdef SET_TIMEOUT_EN
      if (m_idle >= TMO) m_field = 0;
`endif
    end
  endfunction

  function automatic logic [21:0] model_out();
    int bl;
    bl = (m_field != 0 && ((m_since / BLINK) % 2) == 0) ? 1 : 0;
    return pack((m_field != 0) ? 1 : 0, m_field, m_h, m_m, m_s, m_load, bl);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit sh, input bit lg);
    rst            = r;
    short_pression = sh;
    long_pression  = lg;
    model_step(r, sh, lg, int'(cur_hour), int'(cur_min), int'(cur_sec));
    @(posedge sysclk);
    #1;
    rst            = 1'b0;
    short_pression = 1'b0;
    long_pression  = 1'b0;
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    cur_hour = h[4:0];
    cur_min  = mi[5:0];
    cur_sec  = s[5:0];
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit sh;
    bit lg;
    int ch, cm, cs;
    int mode, ef, h, mi, s, ld, bl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit sh, input bit lg, input int ch, input int cm, input int cs,
                     input int mode, input int ef, input int h, input int mi, input int s,
                     input int ld, input int bl);
    vec_t v;
    v.sh = sh; v.lg = lg; v.ch = ch; v.cm = cm; v.cs = cs;
    v.mode = mode; v.ef = ef; v.h = h; v.mi = mi; v.s = s; v.ld = ld; v.bl = bl;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; short_pression = 1'b0; long_pression = 1'b0;
    set_cur(0, 0, 0);
    m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_since = 0; m_idle = 0; m_load = 0;

    // reset state
    step(1, 0, 0);
    step(1, 0, 0);
    check("reset", dut_out(), pack(0, 0, 0, 0, 0, 0, 0));

    //      sh lg  cur          mode ef  h  mi  s  ld bl
    // enter at 12:34:56, three hour increments, walk through with no edits
    add(0, 1, 12, 34, 56,  1, 1, 12, 34, 56, 0, 1);
    add(1, 0, 12, 34, 56,  1, 1, 13, 34, 56, 0, 1);
    add(1, 0, 12, 34, 56,  1, 1, 14, 34, 56, 0, 1);
    add(1, 0, 12, 34, 56,  1, 1, 15, 34, 56, 0, 1);
    add(0, 1, 12, 34, 56,  1, 2, 15, 34, 56, 0, 1);
    add(0, 1, 12, 34, 56,  1, 3, 15, 34, 56, 0, 1);
    add(0, 1, 12, 34, 56,  0, 0, 15, 34, 56, 1, 0);
    add(0, 0, 12, 34, 56,  0, 0, 15, 34, 56, 0, 0);
    // full pass with two second increments
    add(0, 1, 12, 34, 56,  1, 1, 12, 34, 56, 0, 1);
    add(0, 1, 12, 34, 56,  1, 2, 12, 34, 56, 0, 1);
    add(0, 1, 12, 34, 56,  1, 3, 12, 34, 56, 0, 1);
    add(1, 0, 12, 34, 56,  1, 3, 12, 34, 57, 0, 1);
    add(1, 0, 12, 34, 56,  1, 3, 12, 34, 58, 0, 1);
    add(0, 1, 12, 34, 56,  0, 0, 12, 34, 58, 1, 0);
    add(0, 0, 12, 34, 56,  0, 0, 12, 34, 58, 0, 0);
    // hour and minute wrap
    add(0, 1, 22, 58,  0,  1, 1, 22, 58,  0, 0, 1);
    add(1, 0, 22, 58,  0,  1, 1, 23, 58,  0, 0, 1);
    add(1, 0, 22, 58,  0,  1, 1,  0, 58,  0, 0, 1);
    add(1, 0, 22, 58,  0,  1, 1,  1, 58,  0, 0, 1);
    add(0, 1, 22, 58,  0,  1, 2,  1, 58,  0, 0, 1);
    add(1, 0, 22, 58,  0,  1, 2,  1, 59,  0, 0, 1);
    add(1, 0, 22, 58,  0,  1, 2,  1,  0,  0, 0, 1);
    // short+long together in SET_MIN: advance, minute untouched
    add(1, 1, 22, 58,  0,  1, 3,  1,  0,  0, 0, 1);
    add(0, 1, 22, 58,  0,  0, 0,  1,  0,  0, 1, 0);
    // out-of-range snapshot wraps to 0 on increment
    add(0, 1, 31, 63, 63,  1, 1, 31, 63, 63, 0, 1);
    add(1, 0, 31, 63, 63,  1, 1,  0, 63, 63, 0, 1);
    add(0, 1, 31, 63, 63,  1, 2,  0, 63, 63, 0, 1);
    add(1, 0, 31, 63, 63,  1, 2,  0,  0, 63, 0, 1);
    add(0, 1, 31, 63, 63,  1, 3,  0,  0, 63, 0, 1);
    add(1, 0, 31, 63, 63,  1, 3,  0,  0,  0, 0, 1);
    add(0, 1, 31, 63, 63,  0, 0,  0,  0,  0, 1, 0);
    // short in RUN is ignored
    add(1, 0, 10, 10, 10,  0, 0,  0,  0,  0, 0, 0);

    foreach (vecs[i]) begin
      set_cur(vecs[i].ch, vecs[i].cm, vecs[i].cs);
      step(0, vecs[i].sh, vecs[i].lg);
      check($sformatf("vec%0d", i), dut_out(),
            pack(vecs[i].mode, vecs[i].ef, vecs[i].h, vecs[i].mi, vecs[i].s,
                 vecs[i].ld, vecs[i].bl));
    end

    // idle in SET_HOUR: blink 4 on / 4 off; timeout (if built in) after 20
    set_cur(10, 20, 30);
    step(0, 0, 1);
    check("idle_enter", dut_out(), pack(1, 1, 10, 20, 30, 0, 1));
`ifdef SET_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      step(0, 0, 0);
      if (k < TMO)
        check($sformatf("idle_k%0d", k), dut_out(),
              pack(1, 1, 10, 20, 30, 0, ((k / 4) % 2 == 0) ? 1 : 0));
      else
        check("timeout_exit", dut_out(), pack(0, 0, 10, 20, 30, 0, 0));
    end
    // a press on the expiry cycle is accepted and restarts the timeout
    step(0, 0, 1);
    for (int k = 1; k < TMO; k++) step(0, 0, 0);
    step(0, 1, 0);
    check("expiry_press", dut_out(), pack(1, 1, 11, 20, 30, 0, 1));
    for (int k = 1; k < TMO; k++) step(0, 0, 0);
    check("expiry_still_set", dut_out(), pack(1, 1, 11, 20, 30, 0, 1));
    step(0, 0, 0);
    check("expiry_timeout", dut_out(), pack(0, 0, 11, 20, 30, 0, 0));
`else
    for (int k = 1; k <= 100; k++) begin
      step(0, 0, 0);
      check($sformatf("idle_k%0d", k), dut_out(),
            pack(1, 1, 10, 20, 30, 0, ((k / 4) % 2 == 0) ? 1 : 0));
    end
`endif

    // reset mid-edit in SET_MIN discards the edit; following short ignored
    set_cur(5, 6, 7);
    step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    check("pre_rst_min", dut_out(), pack(1, 2, 5, 7, 7, 0, 1));
    step(1, 0, 0);
    check("rst_mid_edit", dut_out(), pack(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0);
    check("short_after_rst", dut_out(), pack(0, 0, 0, 0, 0, 0, 0));

    // randomized run against the model; press density changes per phase
    begin
      int pct;
      pct = 20;
      for (int c = 0; c < 4000; c++) begin
        bit r, sh, lg;
        if (c % 400 == 0) pct = $urandom_range(1, 40);
        if ($urandom_range(0, 9) == 0) set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        else                           set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        r  = ($urandom_range(0, 499) == 0);
        sh = ($urandom_range(0, 99) < pct);
        lg = ($urandom_range(0, 199) < pct);
        step(r, sh, lg);
        check($sformatf("rand%0d", c), dut_out(), model_out());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
